// File: rtl/debug_pkg.sv
// Shared constants for the debug unit: UART command codes, replies,
// FSM state encoding and the default dump sizes.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] ACK       = 8'h4B;
  localparam logic [7:0] NAK       = 8'h3F;

  localparam int DUMP_REGS = 32;
  localparam int DUMP_MEMW = 32;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_LOAD_CNT   = 4'd1;
  localparam logic [3:0] ST_LOAD_BYTE  = 4'd2;
  localparam logic [3:0] ST_LOAD_WRITE = 4'd3;
  localparam logic [3:0] ST_RUN        = 4'd4;
  localparam logic [3:0] ST_STEP       = 4'd5;
  localparam logic [3:0] ST_DUMP_ADDR  = 4'd6;
  localparam logic [3:0] ST_DUMP_CAP   = 4'd7;
  localparam logic [3:0] ST_SEND       = 4'd8;
  localparam logic [3:0] ST_SEND_WAIT  = 4'd9;

endpackage

// File: rtl/dunit_word_serializer.sv
// Sends a word MSB-first as NB_REG/NB_BYTE UART bytes (or only the top
// byte when single is set), one tx_start per byte, paced by tx_done.
module dunit_word_serializer #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               single,
  input  logic [NB_REG-1:0]  word,
  input  logic               tx_done,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_start,
  output logic               done
);
  localparam int BPW = NB_REG / NB_BYTE;
  localparam int CW  = $clog2(BPW) + 1;

  logic [NB_REG-1:0] sh;
  logic [CW-1:0]     left;
  logic              pend, busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      left     <= '0;
      pend     <= 1'b0;
      busy     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (load) begin
        sh   <= word;
        left <= single ? CW'(1) : CW'(BPW);
        pend <= 1'b1;
      end else if (pend) begin
        tx_start <= 1'b1;
        tx_data  <= sh[NB_REG-1 -: NB_BYTE];
        pend     <= 1'b0;
        busy     <= 1'b1;
      end else if (busy && tx_done) begin
        // next start is launched from pend, a cycle after tx_done
        sh   <= sh << NB_BYTE;
        left <= left - CW'(1);
        if (left == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// UART-driven debug controller: loads instruction memory, resets the PC,
// runs/steps the processor and dumps register file plus data memory.
module debug_unit
  import debug_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8,
  parameter int N_REGS  = DUMP_REGS,
  parameter int N_MEMW  = DUMP_MEMW
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data
);
  localparam int BPW = NB_REG / NB_BYTE;
  localparam int BCW = $clog2(BPW);

  logic [3:0]                state;
  logic                      halted, in_dump, dump_mem, step_wait;
  logic [NB_BYTE-1:0]        n_words, widx;
  logic [BCW-1:0]            bcnt;
  logic [NB_REG-NB_BYTE-1:0] ld_sh;
  logic [NB_REG-1:0]         j, tx_word;
  logic                      tx_single, ser_load, ser_done;

  assign ser_load = (state == ST_SEND);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state            <= ST_IDLE;
      halted           <= 1'b0;
      in_dump          <= 1'b0;
      dump_mem         <= 1'b0;
      step_wait        <= 1'b0;
      n_words          <= '0;
      widx             <= '0;
      bcnt             <= '0;
      ld_sh            <= '0;
      j                <= '0;
      tx_word          <= '0;
      tx_single        <= 1'b0;
      o_dunit_clk_en   <= 1'b0;
      o_dunit_reset_pc <= 1'b0;
      o_dunit_w_mem    <= 1'b0;
      o_dunit_addr     <= '0;
      o_dunit_data     <= '0;
    end else begin
      o_dunit_reset_pc <= 1'b0;
      o_dunit_w_mem    <= 1'b0;
      case (state)
        ST_IDLE: if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state <= ST_LOAD_CNT;
            CMD_RESET: begin
              o_dunit_reset_pc <= 1'b1;
              halted           <= 1'b0;
              tx_word          <= NB_REG'(ACK) << (NB_REG - 8);
              tx_single        <= 1'b1;
              state            <= ST_SEND;
            end
            CMD_CONT, CMD_STEP: begin
              // a halted core is never clocked again until 'R'
              if (halted) state <= ST_DUMP_ADDR;
              else begin
                o_dunit_clk_en <= 1'b1;
                step_wait      <= 1'b0;
                state          <= (i_rx_data == CMD_CONT) ? ST_RUN : ST_STEP;
              end
            end
            default: begin
              tx_word   <= NB_REG'(NAK) << (NB_REG - 8);
              tx_single <= 1'b1;
              state     <= ST_SEND;
            end
          endcase
        end
        ST_LOAD_CNT: if (i_rx_valid) begin
          n_words <= i_rx_data;
          widx    <= '0;
          bcnt    <= '0;
          if (i_rx_data == '0) begin
            tx_word   <= NB_REG'(ACK) << (NB_REG - 8);
            tx_single <= 1'b1;
            state     <= ST_SEND;
          end else begin
            state <= ST_LOAD_BYTE;
          end
        end
        ST_LOAD_BYTE: if (i_rx_valid) begin
          if (bcnt == BCW'(BPW - 1)) begin
            o_dunit_addr  <= NB_REG'(widx) << 2;
            o_dunit_data  <= {ld_sh, i_rx_data};
            o_dunit_w_mem <= 1'b1;
            bcnt          <= '0;
            state         <= ST_LOAD_WRITE;
          end else begin
            ld_sh <= {ld_sh[NB_REG-2*NB_BYTE-1:0], i_rx_data};
            bcnt  <= bcnt + BCW'(1);
          end
        end
        ST_LOAD_WRITE: begin
          widx <= widx + NB_BYTE'(1);
          if (widx + NB_BYTE'(1) == n_words) begin
            tx_word   <= NB_REG'(ACK) << (NB_REG - 8);
            tx_single <= 1'b1;
            state     <= ST_SEND;
          end else begin
            state <= ST_LOAD_BYTE;
          end
        end
        ST_RUN: if (i_halt) begin
          o_dunit_clk_en <= 1'b0;
          halted         <= 1'b1;
          state          <= ST_DUMP_ADDR;
        end
        ST_STEP: begin
          // second cycle samples i_halt after the single pipeline advance
          if (!step_wait) begin
            o_dunit_clk_en <= 1'b0;
            step_wait      <= 1'b1;
          end else begin
            step_wait <= 1'b0;
            if (i_halt) halted <= 1'b1;
            state <= ST_DUMP_ADDR;
          end
        end
        ST_DUMP_ADDR: begin
          o_dunit_addr <= dump_mem ? (j << 2) : j;
          state        <= ST_DUMP_CAP;
        end
        ST_DUMP_CAP: begin
          tx_word   <= dump_mem ? i_dunit_mem_data : i_dunit_reg;
          tx_single <= 1'b0;
          in_dump   <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: state <= ST_SEND_WAIT;
        ST_SEND_WAIT: if (ser_done) begin
          if (!in_dump) state <= ST_IDLE;
          else if (!dump_mem && j == NB_REG'(N_REGS - 1)) begin
            dump_mem <= 1'b1;
            j        <= '0;
            state    <= ST_DUMP_ADDR;
          end else if (dump_mem && j == NB_REG'(N_MEMW - 1)) begin
            dump_mem <= 1'b0;
            in_dump  <= 1'b0;
            j        <= '0;
            state    <= ST_IDLE;
          end else begin
            j     <= j + NB_REG'(1);
            state <= ST_DUMP_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dunit_word_serializer #(.NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) u_ser (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .load     (ser_load),
    .single   (tx_single),
    .word     (tx_word),
    .tx_done  (i_tx_done),
    .tx_data  (o_tx_data),
    .tx_start (o_tx_start),
    .done     (ser_done)
  );

endmodule
